// File: rtl/writeback_arbiter_pkg.sv
// Shared constants and helpers for the writeback arbiter and its load FIFO.
// Register-file geometry lives here so both files agree on address width.
package writeback_arbiter_pkg;

    localparam int DATAWIDTH_DEF = 32;
    localparam int REG_ADDR_W    = 5;
    localparam int NUM_REGS      = 32;

    localparam logic [REG_ADDR_W-1:0] X0_IDX = '0;

    // x0 is hardwired zero, so it never appears in the hazard mask
    function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_ADDR_W-1:0] rd);
        rd_onehot = '0;
        if (rd != X0_IDX) begin
            rd_onehot[rd] = 1'b1;
        end
    endfunction

endpackage

// File: rtl/wb_load_fifo.sv
// Load-response FIFO for the writeback stage: storage, wrap-bit pointers,
// occupancy and the per-entry destination mask consumed by the hazard unit.
module wb_load_fifo
    import writeback_arbiter_pkg::*;
#(
    parameter  int DATAWIDTH = DATAWIDTH_DEF,
    parameter  int LD_DEPTH  = 4,
    localparam int AW        = $clog2(LD_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [REG_ADDR_W-1:0] push_rd,
    input  logic [DATAWIDTH-1:0]  push_data,
    input  logic                  pop,
    output logic [REG_ADDR_W-1:0] head_rd,
    output logic [DATAWIDTH-1:0]  head_data,
    output logic                  empty,
    output logic [AW:0]           count,
    output logic [NUM_REGS-1:0]   pending
);

    logic [AW:0]           wptr, rptr;
    logic [REG_ADDR_W-1:0] rd_mem   [LD_DEPTH];
    logic [DATAWIDTH-1:0]  data_mem [LD_DEPTH];
    logic [LD_DEPTH-1:0]   vld_mem;
    logic                  clr_vld_p1;
    logic [AW-1:0]         clr_idx_p1;

    assign empty     = (wptr == rptr);
    assign count     = wptr - rptr;
    assign head_rd   = rd_mem[rptr[AW-1:0]];
    assign head_data = data_mem[rptr[AW-1:0]];

    // A popped entry stays visible in the mask until its register-file write
    // has landed, hence the one-cycle delayed clear. A push into the same slot
    // on that edge is ordered after the clear and wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr       <= '0;
            rptr       <= '0;
            vld_mem    <= '0;
            clr_vld_p1 <= 1'b0;
            clr_idx_p1 <= '0;
        end else begin
            clr_vld_p1 <= pop;
            clr_idx_p1 <= rptr[AW-1:0];
            if (clr_vld_p1) begin
                vld_mem[clr_idx_p1] <= 1'b0;
            end
            if (push) begin
                vld_mem[wptr[AW-1:0]] <= 1'b1;
                wptr                  <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[wptr[AW-1:0]]   <= push_rd;
            data_mem[wptr[AW-1:0]] <= push_data;
        end
    end

    always_comb begin
        pending = '0;
        for (int i = 0; i < LD_DEPTH; i++) begin
            if (vld_mem[i]) begin
                pending = pending | rd_onehot(rd_mem[i]);
            end
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Writeback stage: merges ALU results and queued load responses onto the
// single register-file write port, with starvation forcing for the load queue.
module writeback_arbiter
    import writeback_arbiter_pkg::*;
#(
    parameter  int DATAWIDTH    = DATAWIDTH_DEF,
    parameter  int LD_DEPTH     = 4,
    parameter  int STARVE_LIMIT = 8,
    localparam int CW           = $clog2(LD_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [DATAWIDTH-1:0]  alu_data,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [REG_ADDR_W-1:0] ld_rd,
    input  logic [DATAWIDTH-1:0]  ld_data,
    output logic                  rf_write,
    output logic [REG_ADDR_W-1:0] rf_writeReg,
    output logic [DATAWIDTH-1:0]  rf_writeData,
    output logic [NUM_REGS-1:0]   ld_pending,
    output logic [CW-1:0]         ld_count
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [SW-1:0]         starve_cnt;
    logic                  force_pop;
    logic                  alu_take, push, pop;
    logic                  fifo_empty;
    logic [REG_ADDR_W-1:0] head_rd;
    logic [DATAWIDTH-1:0]  head_data;
    logic                  wr_en;
    logic [REG_ADDR_W-1:0] wr_rd;
    logic [DATAWIDTH-1:0]  wr_data;

    wb_load_fifo #(
        .DATAWIDTH (DATAWIDTH),
        .LD_DEPTH  (LD_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_rd   (ld_rd),
        .push_data (ld_data),
        .pop       (pop),
        .head_rd   (head_rd),
        .head_data (head_data),
        .empty     (fifo_empty),
        .count     (ld_count),
        .pending   (ld_pending)
    );

    // Handshakes depend only on registered state; ld_ready uses the pre-pop count
    assign force_pop = (starve_cnt == SW'(STARVE_LIMIT));
    assign alu_ready = !force_pop;
    assign ld_ready  = (ld_count < CW'(LD_DEPTH));
    assign alu_take  = alu_valid && alu_ready;
    assign push      = ld_valid && ld_ready;
    assign pop       = !alu_take && !fifo_empty;

    always_comb begin
        wr_rd   = alu_take ? alu_rd   : head_rd;
        wr_data = alu_take ? alu_data : head_data;
        wr_en   = (alu_take || pop) && (wr_rd != X0_IDX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_write     <= 1'b0;
            rf_writeReg  <= '0;
            rf_writeData <= '0;
            starve_cnt   <= '0;
        end else begin
            rf_write <= wr_en;
            if (wr_en) begin
                rf_writeReg  <= wr_rd;
                rf_writeData <= wr_data;
            end
            if (fifo_empty || pop) begin
                starve_cnt <= '0;
            end else if (!force_pop) begin
                starve_cnt <= starve_cnt + SW'(1);
            end
        end
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: ALU path, load path, fill/backpressure,
// starvation forcing, x0 suppression and asynchronous reset mid-run.
module tb_writeback_arbiter;

    logic        clk;
    logic        rst_n;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        rf_write;
    logic [4:0]  rf_writeReg;
    logic [31:0] rf_writeData;
    logic [31:0] ld_pending;
    logic [2:0]  ld_count;

    int n_chk  = 0;
    int n_pass = 0;

    writeback_arbiter #(
        .DATAWIDTH    (32),
        .LD_DEPTH     (4),
        .STARVE_LIMIT (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .alu_valid    (alu_valid),
        .alu_ready    (alu_ready),
        .alu_rd       (alu_rd),
        .alu_data     (alu_data),
        .ld_valid     (ld_valid),
        .ld_ready     (ld_ready),
        .ld_rd        (ld_rd),
        .ld_data      (ld_data),
        .rf_write     (rf_write),
        .rf_writeReg  (rf_writeReg),
        .rf_writeData (rf_writeData),
        .ld_pending   (ld_pending),
        .ld_count     (ld_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        logic [4:0] drain_rd [4];
        drain_rd[0] = 5'd11;
        drain_rd[1] = 5'd12;
        drain_rd[2] = 5'd13;
        drain_rd[3] = 5'd20;

        rst_n     = 1'b0;
        alu_valid = 1'b0;
        alu_rd    = '0;
        alu_data  = '0;
        ld_valid  = 1'b0;
        ld_rd     = '0;
        ld_data   = '0;
        step();
        step();
        chk("rst_rf_write", 32'(rf_write), 32'd0);
        chk("rst_rf_reg", 32'(rf_writeReg), 32'd0);
        chk("rst_rf_data", rf_writeData, 32'd0);
        chk("rst_pending", ld_pending, 32'd0);
        chk("rst_count", 32'(ld_count), 32'd0);
        chk("rst_ld_ready", 32'(ld_ready), 32'd1);
        chk("rst_alu_ready", 32'(alu_ready), 32'd1);
        rst_n = 1'b1;
        step();

        // ALU only
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        chk("alu_ready", 32'(alu_ready), 32'd1);
        step();
        alu_valid = 1'b0;
        chk("alu_wr", 32'(rf_write), 32'd1);
        chk("alu_reg", 32'(rf_writeReg), 32'd5);
        chk("alu_data", rf_writeData, 32'hDEADBEEF);
        step();
        chk("alu_idle_wr", 32'(rf_write), 32'd0);
        chk("alu_hold_reg", 32'(rf_writeReg), 32'd5);
        chk("alu_hold_data", rf_writeData, 32'hDEADBEEF);

        // Load only
        ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h12345678;
        chk("ld_ready", 32'(ld_ready), 32'd1);
        step();
        ld_valid = 1'b0;
        chk("ld_pend_set", ld_pending, 32'h0000_0080);
        chk("ld_count1", 32'(ld_count), 32'd1);
        chk("ld_no_bypass", 32'(rf_write), 32'd0);
        step();
        chk("ld_wr", 32'(rf_write), 32'd1);
        chk("ld_reg", 32'(rf_writeReg), 32'd7);
        chk("ld_data", rf_writeData, 32'h12345678);
        chk("ld_count0", 32'(ld_count), 32'd0);
        chk("ld_pend_hold", ld_pending, 32'h0000_0080);
        step();
        chk("ld_pend_clr", ld_pending, 32'd0);
        chk("ld_idle_wr", 32'(rf_write), 32'd0);

        // Fill with ALU held valid
        alu_valid = 1'b1; alu_rd = 5'd3;
        for (int i = 0; i < 4; i++) begin
            ld_valid = 1'b1;
            ld_rd    = 5'(10 + i);
            ld_data  = 32'h1000 + 32'(10 + i);
            alu_data = 32'hA000 + 32'(i);
            chk("fill_ld_ready", 32'(ld_ready), 32'd1);
            step();
        end
        ld_rd = 5'd20; ld_data = 32'h1014;
        chk("full_ld_ready", 32'(ld_ready), 32'd0);
        chk("full_count", 32'(ld_count), 32'd4);
        chk("full_pending", ld_pending, 32'h0000_3C00);
        chk("full_alu_data", rf_writeData, 32'hA003);
        for (int i = 0; i < 5; i++) begin
            alu_data = 32'hB000 + 32'(i);
            chk("stall_alu_ready", 32'(alu_ready), 32'd1);
            step();
            chk("stall_count", 32'(ld_count), 32'd4);
            chk("stall_ld_ready", 32'(ld_ready), 32'd0);
        end
        chk("force_alu_ready", 32'(alu_ready), 32'd0);
        chk("force_alu_data", rf_writeData, 32'hB004);
        alu_data = 32'hC000;
        step();
        chk("force_wr", 32'(rf_write), 32'd1);
        chk("force_reg", 32'(rf_writeReg), 32'd10);
        chk("force_data", rf_writeData, 32'h100A);
        chk("force_count", 32'(ld_count), 32'd3);
        chk("force_ld_ready", 32'(ld_ready), 32'd1);
        chk("resume_alu_ready", 32'(alu_ready), 32'd1);
        step();
        ld_valid = 1'b0; alu_valid = 1'b0;
        chk("refill_count", 32'(ld_count), 32'd4);
        chk("refill_reg", 32'(rf_writeReg), 32'd3);
        chk("refill_data", rf_writeData, 32'hC000);
        chk("refill_pending", ld_pending, 32'h0010_3800);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("drain_wr", 32'(rf_write), 32'd1);
            chk("drain_reg", 32'(rf_writeReg), 32'(drain_rd[i]));
            chk("drain_data", rf_writeData, 32'h1000 + 32'(drain_rd[i]));
        end
        step();
        chk("drained_count", 32'(ld_count), 32'd0);
        chk("drained_pending", ld_pending, 32'd0);
        chk("drained_wr", 32'(rf_write), 32'd0);

        // Starvation with a single queued load
        ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h99;
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h44;
        step();
        ld_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("starve_alu_ready", 32'(alu_ready), 32'd1);
            step();
        end
        chk("starve_force", 32'(alu_ready), 32'd0);
        chk("starve_last_alu", 32'(rf_writeReg), 32'd4);
        step();
        chk("starve_ld_reg", 32'(rf_writeReg), 32'd9);
        chk("starve_ld_data", rf_writeData, 32'h99);
        chk("starve_resume", 32'(alu_ready), 32'd1);
        chk("starve_cnt_clr", 32'(dut.starve_cnt), 32'd0);
        step();
        chk("starve_alu_wr", 32'(rf_write), 32'd1);
        chk("starve_alu_reg", 32'(rf_writeReg), 32'd4);
        alu_valid = 1'b0;
        step();

        // x0 destinations
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFFFFFF;
        step();
        alu_valid = 1'b0;
        chk("x0_alu_wr", 32'(rf_write), 32'd0);
        chk("x0_alu_hold", rf_writeData, 32'h44);
        ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'h5555;
        step();
        ld_valid = 1'b0;
        chk("x0_ld_count", 32'(ld_count), 32'd1);
        chk("x0_ld_pending", ld_pending, 32'd0);
        step();
        chk("x0_ld_wr", 32'(rf_write), 32'd0);
        chk("x0_ld_popped", 32'(ld_count), 32'd0);
        chk("x0_ld_hold", rf_writeData, 32'h44);

        // Reset mid-run
        alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 32'h66;
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1'b1;
            ld_rd    = 5'(1 + i);
            ld_data  = 32'h2000 + 32'(i);
            step();
        end
        ld_valid = 1'b0;
        chk("pre_rst_count", 32'(ld_count), 32'd3);
        chk("pre_rst_pending", ld_pending, 32'h0000_000E);
        chk("pre_rst_wr", 32'(rf_write), 32'd1);
        rst_n = 1'b0; alu_valid = 1'b0;
        #1;
        chk("async_rst_count", 32'(ld_count), 32'd0);
        chk("async_rst_pending", ld_pending, 32'd0);
        chk("async_rst_wr", 32'(rf_write), 32'd0);
        chk("async_rst_reg", 32'(rf_writeReg), 32'd0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_wr", 32'(rf_write), 32'd0);
            chk("post_rst_count", 32'(ld_count), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
